// File: rtl/pipelined_adder.sv
// rtl/pipelined_adder.sv - pipelined add/subtract with carry-in, overflow and valid/ready handshake
module pipelined_adder #(
    parameter int WIDTH  = 32,
    parameter int STAGES = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] x,
    input  logic [WIDTH-1:0] y,
    input  logic             cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);

    localparam int C = WIDTH / STAGES;

    if (WIDTH < 1 || STAGES < 1 || STAGES > WIDTH || (WIDTH % STAGES) != 0) begin : g_param_check
        $error("pipelined_adder: need WIDTH >= 1, 1 <= STAGES <= WIDTH, WIDTH divisible by STAGES");
    end

    logic             advance;
    logic [WIDTH-1:0] yb;
    logic             c0;

    // Subtraction is x + ~y + 1; cin flips the injected carry so it acts as borrow-in.
    assign yb       = sub ? ~y : y;
    assign c0       = cin ^ sub;

    // One global stall: the whole pipe moves only when the output slot is free or draining.
    assign advance  = !out_valid || out_ready;
    assign in_ready = advance;

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        localparam int LO = k * C;
        localparam int HI = (k + 1) * C;

        logic [C-1:0]  a;
        logic [C-1:0]  b;
        logic          ci;
        logic [C:0]    r;
        logic [HI-1:0] s_d;
        logic [HI-1:0] s_q;
        logic          c_q;
        logic          v_d;
        logic          v_q;

        // Stage 0 takes the live operands; later stages take the chunk the previous stage carried forward.
        if (k == 0) begin : g_first
            assign a   = x[C-1:0];
            assign b   = yb[C-1:0];
            assign ci  = c0;
            assign s_d = r[C-1:0];
            assign v_d = in_valid;
        end else begin : g_next
            assign a   = g_stage[k-1].g_ops.x_q[C-1:0];
            assign b   = g_stage[k-1].g_ops.y_q[C-1:0];
            assign ci  = g_stage[k-1].c_q;
            assign s_d = {r[C-1:0], g_stage[k-1].s_q};
            assign v_d = g_stage[k-1].v_q;
        end

        assign r = {1'b0, a} + {1'b0, b} + {{C{1'b0}}, ci};

        // Accumulated low sum bits, chunk carry and valid advance together with the beat.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                s_q <= '0;
                c_q <= 1'b0;
                v_q <= 1'b0;
            end else if (advance) begin
                s_q <= s_d;
                c_q <= r[C];
                v_q <= v_d;
            end
        end

        // Operand bits not yet summed ride along; the last stage has none left to carry.
        if (HI < WIDTH) begin : g_ops
            logic [WIDTH-HI-1:0] x_d;
            logic [WIDTH-HI-1:0] y_d;
            logic [WIDTH-HI-1:0] x_q;
            logic [WIDTH-HI-1:0] y_q;

            if (k == 0) begin : g_src_in
                assign x_d = x[WIDTH-1:HI];
                assign y_d = yb[WIDTH-1:HI];
            end else begin : g_src_prev
                assign x_d = g_stage[k-1].g_ops.x_q[WIDTH-LO-1:C];
                assign y_d = g_stage[k-1].g_ops.y_q[WIDTH-LO-1:C];
            end

            // Upper operand slices shift with the beat so data stays aligned with its carry.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    x_q <= '0;
                    y_q <= '0;
                end else if (advance) begin
                    x_q <= x_d;
                    y_q <= y_d;
                end
            end
        end

        if (k == STAGES - 1) begin : g_last
            logic ovf_q;

            // Carry into the MSB is a^b^sum at that bit; overflow is it XOR the final carry out.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    ovf_q <= 1'b0;
                end else if (advance) begin
                    ovf_q <= a[C-1] ^ b[C-1] ^ r[C-1] ^ r[C];
                end
            end
        end
    end

    assign sum       = g_stage[STAGES-1].s_q;
    assign cout      = g_stage[STAGES-1].c_q;
    assign ovf       = g_stage[STAGES-1].g_last.ovf_q;
    assign out_valid = g_stage[STAGES-1].v_q;

endmodule

// File: tb/tb_pipelined_adder.sv
// tb/tb_pipelined_adder.sv - table and scoreboard bench for pipelined_adder
module tb_pipelined_adder;

    localparam int W = 32;
    localparam int S = 4;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [W-1:0] x = '0;
    logic [W-1:0] y = '0;
    logic         cin = 1'b0;
    logic         sub = 1'b0;
    logic         out_valid;
    logic         out_ready = 1'b0;
    logic [W-1:0] sum;
    logic         cout;
    logic         ovf;

    always #5 clk = ~clk;

    pipelined_adder #(.WIDTH(W), .STAGES(S)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .x(x), .y(y), .cin(cin), .sub(sub),
        .out_valid(out_valid), .out_ready(out_ready),
        .sum(sum), .cout(cout), .ovf(ovf)
    );

    typedef struct {
        logic [W-1:0] sum;
        logic         cout;
        logic         ovf;
        int           acc;
    } exp_t;

    typedef struct {
        logic [W-1:0] x;
        logic [W-1:0] y;
        logic         cin;
        logic         sub;
        logic [W-1:0] esum;
        logic         ecout;
        logic         eovf;
    } vec_t;

    exp_t         q[$];
    exp_t         drv_exp;
    vec_t         tab[8];
    int           checks = 0;
    int           failures = 0;
    int           cyc = 0;
    bit           lat_chk = 0;
    bit           acc_flag = 0;
    bit           prev_stall = 0;
    logic [W+2:0] prev_out;

    function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b,
                                   input logic ci, input logic s);
        logic [W-1:0] bb;
        logic [W:0]   r;
        exp_t         e;
        bb     = s ? ~b : b;
        r      = {1'b0, a} + {1'b0, bb} + {{W{1'b0}}, ci ^ s};
        e.sum  = r[W-1:0];
        e.cout = r[W];
        e.ovf  = (a[W-1] == bb[W-1]) && (r[W-1] != a[W-1]);
        e.acc  = 0;
        return e;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    task automatic drive(input logic [W-1:0] a, input logic [W-1:0] b, input logic ci,
                         input logic s, input exp_t e);
        in_valid = 1'b1;
        x        = a;
        y        = b;
        cin      = ci;
        sub      = s;
        drv_exp  = e;
    endtask

    task automatic drive_rand();
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic         ci;
        logic         s;
        a  = $urandom;
        b  = $urandom;
        ci = 1'($urandom_range(0, 1));
        s  = 1'($urandom_range(0, 1));
        drive(a, b, ci, s, model(a, b, ci, s));
    endtask

    task automatic cycle();
        exp_t e;
        @(negedge clk);
        cyc++;
        check("in_ready", {63'd0, in_ready}, {63'd0, !(out_valid && !out_ready)});
        if (prev_stall)
            check("stall_hold", {29'd0, out_valid, cout, ovf, sum}, {29'd0, prev_out});
        prev_stall = out_valid && !out_ready;
        prev_out   = {out_valid, cout, ovf, sum};
        if (out_valid && out_ready) begin
            if (q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_beat actual=%0h required=none", sum);
            end else begin
                e = q.pop_front();
                check("result", {30'd0, cout, ovf, sum}, {30'd0, e.cout, e.ovf, e.sum});
                if (lat_chk)
                    check("latency", 64'(cyc - e.acc), 64'(S));
            end
        end
        acc_flag = in_valid && in_ready;
        if (acc_flag) begin
            e     = drv_exp;
            e.acc = cyc;
            q.push_back(e);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic drain(input int budget);
        int n;
        n        = 0;
        in_valid = 1'b0;
        while (q.size() != 0 && n < budget) begin
            cycle();
            n++;
        end
        if (q.size() != 0) begin
            checks++;
            failures++;
            $display("FAIL drain_timeout actual=%0d required=0", q.size());
        end
    endtask

    task automatic expect_reset_outputs(input string name);
        check(name, {29'd0, out_valid, cout, ovf, sum}, 64'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        tab[0] = '{32'hFFFFFFFF, 32'h1, 1'b0, 1'b0, 32'h00000000, 1'b1, 1'b0};
        tab[1] = '{32'h000000FF, 32'h1, 1'b0, 1'b0, 32'h00000100, 1'b0, 1'b0};
        tab[2] = '{32'h5,        32'h7, 1'b0, 1'b1, 32'hFFFFFFFE, 1'b0, 1'b0};
        tab[3] = '{32'h7,        32'h5, 1'b1, 1'b1, 32'h00000001, 1'b1, 1'b0};
        tab[4] = '{32'h7FFFFFFF, 32'h1, 1'b0, 1'b0, 32'h80000000, 1'b0, 1'b1};
        tab[5] = '{32'h80000000, 32'h1, 1'b0, 1'b1, 32'h7FFFFFFF, 1'b1, 1'b1};
        tab[6] = '{32'h1,        32'h2, 1'b1, 1'b0, 32'h00000004, 1'b0, 1'b0};
        tab[7] = '{32'h0,        32'h0, 1'b0, 1'b1, 32'h00000000, 1'b1, 1'b0};

        repeat (3) @(posedge clk);
        #1;
        expect_reset_outputs("reset_outputs");
        rst_n     = 1'b1;
        out_ready = 1'b1;
        cycle();

        // Isolated beats: exact latency and chunk-boundary carries.
        lat_chk = 1;
        for (int i = 0; i < 8; i++) begin
            drive(tab[i].x, tab[i].y, tab[i].cin, tab[i].sub,
                  '{tab[i].esum, tab[i].ecout, tab[i].eovf, 0});
            cycle();
            check("accept", {63'd0, acc_flag}, 64'd1);
            drain(20);
        end

        // Same vectors back to back: full throughput at unchanged latency.
        for (int i = 0; i < 8; i++) begin
            drive(tab[i].x, tab[i].y, tab[i].cin, tab[i].sub,
                  '{tab[i].esum, tab[i].ecout, tab[i].eovf, 0});
            cycle();
        end
        drain(20);
        lat_chk = 0;

        // Ten beats with out_ready low for cycles 3..7.
        begin
            int j;
            j = 0;
            drive_rand();
            for (int i = 0; i < 60 && (j < 10 || q.size() != 0); i++) begin
                out_ready = !(i >= 3 && i <= 7);
                if (j >= 10)
                    in_valid = 1'b0;
                cycle();
                if (acc_flag) begin
                    j++;
                    if (j < 10)
                        drive_rand();
                end
            end
            check("bp_done", {62'd0, j == 10, q.size() == 0}, 64'd3);
        end

        // Random valid and backpressure.
        for (int i = 0; i < 400; i++) begin
            out_ready = 1'($urandom_range(0, 9) < 7);
            if (!in_valid || acc_flag || $urandom_range(0, 3) == 0) begin
                if ($urandom_range(0, 3) != 0)
                    drive_rand();
                else
                    in_valid = 1'b0;
            end
            cycle();
        end
        out_ready = 1'b1;
        drain(40);

        // Reset with beats in flight and one at the output.
        for (int i = 0; i < 5; i++) begin
            drive_rand();
            cycle();
        end
        check("pre_reset_valid", {63'd0, out_valid}, 64'd1);
        #2;
        rst_n = 1'b0;
        #1;
        expect_reset_outputs("async_reset");
        q.delete();
        prev_stall = 0;
        in_valid   = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        for (int i = 0; i < 12; i++)
            cycle();
        check("post_reset_empty", {63'd0, out_valid}, 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
